// File: rtl/cont_campo_bcd.sv
// cont_campo_bcd: one clock/timer field counter with PS/2 key editing, run-mode counting and packed BCD output.
// Ports: clk, rst (async, active high); posicion/f1/f3 choose when the field is selected for editing;
// en_codigo/key_code carry the edit keys; run/down/tick drive counting; load/load_val perform a parallel load;
// valor/dato_bcd give the field value; carry pulses on a run wrap; sel shows that the field is selected.
module cont_campo_bcd #(
  parameter int N = 8,
  parameter int P = 2,
  parameter int W = 6,
  parameter int POS_ID = 2,
  parameter int MINIMO = 0,
  parameter int MAXIMO = 59,
  parameter logic [N-1:0] KEY_UP = 8'h75,
  parameter logic [N-1:0] KEY_DN = 8'h72,
  parameter logic [N-1:0] KEY_CLR = 8'h71
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [P-1:0] posicion,
  input  logic         en_codigo,
  input  logic         f1,
  input  logic         f3,
  input  logic [N-1:0] key_code,
  input  logic         run,
  input  logic         down,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] valor,
  output logic [N-1:0] dato_bcd,
  output logic         carry,
  output logic         sel
);
  localparam logic [W-1:0] L_MIN = W'(MINIMO);
  localparam logic [W-1:0] L_MAX = W'(MAXIMO);
  localparam logic [P-1:0] L_POS = P'(POS_ID);

  // Tens are found by repeated subtraction of 10. Nine steps are enough for any value up to 99.
  function automatic logic [N-1:0] to_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   t;
    r = v;
    t = '0;
    for (int i = 0; i < 9; i++)
      if (r >= W'(10)) begin
        r = r - W'(10);
        t = t + 4'd1;
      end
    return N'({t, r[3:0]});
  endfunction

  // The +1 keeps the lower-bound check well formed when MINIMO is 0.
  function automatic logic in_rng(input logic [W-1:0] v);
    return (({1'b0, v} + 1'b1) > {1'b0, L_MIN}) && (v <= L_MAX);
  endfunction

  logic [W-1:0] r_valor, w_inc, w_dec, w_nxt;
  logic [N-1:0] r_bcd;
  logic         r_carry, w_cfg, w_edit, w_tick, w_ok, w_carry_nxt;

  always_comb begin
    w_cfg  = f1 | f3;
    sel    = (posicion == L_POS) && w_cfg;
    w_edit = sel && en_codigo;
    // Any configuration mode freezes counting, even when another field is selected.
    w_tick = run && tick && !w_cfg;
    w_ok   = in_rng(r_valor);
    // An out-of-range value, which should never occur, recovers to MINIMO on the next step.
    w_inc  = (!w_ok || r_valor == L_MAX) ? L_MIN : r_valor + 1'b1;
    w_dec  = !w_ok ? L_MIN : (r_valor == L_MIN) ? L_MAX : r_valor - 1'b1;
    w_nxt  = load   ? (in_rng(load_val) ? load_val : L_MIN)
           : w_edit ? (key_code == KEY_UP  ? w_inc
                     : key_code == KEY_DN  ? w_dec
                     : key_code == KEY_CLR ? L_MIN : r_valor)
           : w_tick ? (down ? w_dec : w_inc) : r_valor;
    w_carry_nxt = !load && !w_edit && w_tick && w_ok && (down ? r_valor == L_MIN : r_valor == L_MAX);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_valor <= L_MIN;
      r_bcd   <= to_bcd(L_MIN);
      r_carry <= 1'b0;
    end else begin
      r_valor <= w_nxt;
      r_bcd   <= to_bcd(w_nxt);
      r_carry <= w_carry_nxt;
    end

  assign valor    = r_valor;
  assign dato_bcd = r_bcd;
  assign carry    = r_carry;
endmodule

// File: tb/tb_cont_campo_bcd.sv
// tb_cont_campo_bcd: scoreboard bench for cont_campo_bcd, covering a 0..59 field and a 1..12 field.
module tb_cont_campo_bcd;
  logic       clk = 0, rst = 1;
  logic [1:0] posicion = 0;
  logic       en_codigo = 0, f1 = 0, f3 = 0, run = 0, down = 0, tick = 0, load = 0;
  logic [7:0] key_code = 0;
  logic [5:0] load_val = 0;
  logic [5:0] v0;
  logic [3:0] v1;
  logic [7:0] b0, b1;
  logic       c0, c1, s0, s1;

  always #5 clk = ~clk;

  cont_campo_bcd dut0 (
    .clk(clk), .rst(rst), .posicion(posicion), .en_codigo(en_codigo), .f1(f1), .f3(f3),
    .key_code(key_code), .run(run), .down(down), .tick(tick), .load(load), .load_val(load_val),
    .valor(v0), .dato_bcd(b0), .carry(c0), .sel(s0));

  cont_campo_bcd #(.W(4), .MINIMO(1), .MAXIMO(12)) dut1 (
    .clk(clk), .rst(rst), .posicion(posicion), .en_codigo(en_codigo), .f1(f1), .f3(f3),
    .key_code(key_code), .run(run), .down(down), .tick(tick), .load(load), .load_val(load_val[3:0]),
    .valor(v1), .dato_bcd(b1), .carry(c1), .sel(s1));

  typedef struct {
    int         id;
    logic [5:0] v;
    logic [7:0] b;
    logic       c;
    logic       s;
    string      nm;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;

  task automatic push(input int id, input logic [5:0] v, input logic [7:0] b, input logic c, input logic s, input string nm);
    exp_t e;
    e.id = id; e.v = v; e.b = b; e.c = c; e.s = s; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic cyc(input int id, input logic [5:0] v, input logic [7:0] b, input logic c, input logic s, input string nm);
    @(posedge clk);
    #1;
    en_codigo = 0; tick = 0; load = 0;
    push(id, v, b, c, s, nm);
    @(negedge clk);
    #1;
  endtask

  task automatic ld(input logic [5:0] x);
    load = 1;
    load_val = x;
  endtask

  task automatic key(input logic [7:0] k);
    en_codigo = 1;
    key_code = k;
  endtask

  // Reset is raised between edges; the monitor samples before any further rising edge.
  task automatic arst(input string nm);
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    push(0, 6'd0, 8'h00, 0, 0, nm);
    push(1, 6'd1, 8'h01, 0, 0, {nm, "_v"});
    @(negedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    exp_t e;
    logic [5:0] av;
    logic [7:0] ab;
    logic ac, as;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        av = e.id == 1 ? {2'b00, v1} : v0;
        ab = e.id == 1 ? b1 : b0;
        ac = e.id == 1 ? c1 : c0;
        as = e.id == 1 ? s1 : s0;
        checks++;
        if ({av, ab, ac, as} !== {e.v, e.b, e.c, e.s}) begin
          errors++;
          $display("FAIL %s: got valor=%0d bcd=%h carry=%b sel=%b, expected valor=%0d bcd=%h carry=%b sel=%b",
                   e.nm, av, ab, ac, as, e.v, e.b, e.c, e.s);
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    push(0, 6'd0, 8'h00, 0, 0, "reset");
    push(1, 6'd1, 8'h01, 0, 0, "reset_v");
    @(negedge clk);
    #1;
    rst = 0;
    ld(58);                 cyc(0, 58, 8'h58, 0, 0, "load58");
    arst("async_rst");
    posicion = 2; f1 = 1;
    ld(59);                 cyc(0, 59, 8'h59, 0, 1, "load59");
    key(8'h75);             cyc(0, 0, 8'h00, 0, 1, "edit_up_wrap");
    key(8'h72);             cyc(0, 59, 8'h59, 0, 1, "edit_dn_wrap");
    key(8'h72);             cyc(0, 58, 8'h58, 0, 1, "edit_dn");
    posicion = 1; f1 = 0; f3 = 1;
    key(8'h75);             cyc(0, 58, 8'h58, 0, 0, "gate_pos");
    posicion = 2; f3 = 0;
    key(8'h75);             cyc(0, 58, 8'h58, 0, 0, "gate_mode");
    f3 = 1;
    key(8'h11);             cyc(0, 58, 8'h58, 0, 1, "other_key");
    f3 = 0; run = 1; down = 0;
    tick = 1;               cyc(0, 59, 8'h59, 0, 0, "run_up");
    tick = 1;               cyc(0, 0, 8'h00, 1, 0, "run_wrap_up");
                            cyc(0, 0, 8'h00, 0, 0, "carry_one_cycle");
    down = 1;
    tick = 1;               cyc(0, 59, 8'h59, 1, 0, "run_wrap_dn");
                            cyc(0, 59, 8'h59, 0, 0, "carry_clear_dn");
    tick = 1;               cyc(0, 58, 8'h58, 0, 0, "run_dn");
    ld(20); tick = 1;       cyc(0, 20, 8'h20, 0, 0, "load_over_tick");
    ld(60);                 cyc(0, 0, 8'h00, 0, 0, "load_oor");
    posicion = 0; f1 = 1;
    tick = 1;               cyc(0, 0, 8'h00, 0, 0, "frozen_f1");
    posicion = 2;
    key(8'h75); tick = 1;   cyc(0, 1, 8'h01, 0, 1, "key_over_tick");
    f1 = 0; posicion = 0; down = 0;
    ld(37);                 cyc(0, 37, 8'h37, 0, 0, "load37");
    arst("rst_mid_run");
    tick = 1;               cyc(0, 1, 8'h01, 0, 0, "after_rst");
    run = 0;
    ld(0);                  cyc(1, 1, 8'h01, 0, 0, "v_load0");
    ld(12);                 cyc(1, 12, 8'h12, 0, 0, "v_load12");
    run = 1;
    tick = 1;               cyc(1, 1, 8'h01, 1, 0, "v_wrap");
    ld(7);                  cyc(1, 7, 8'h07, 0, 0, "v_load7");
    posicion = 2; f1 = 1;
    key(8'h71);             cyc(1, 1, 8'h01, 0, 1, "v_clr");
    key(8'h72);             cyc(1, 12, 8'h12, 0, 1, "v_edit_dn_wrap");
    tick = 1;               cyc(1, 12, 8'h12, 0, 1, "v_frozen");
    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
